// File: rtl/accum_seq_pkg.sv
// -----------------------------------------------------------------------------
// accum_seq_pkg
// Shared definitions for the accumulator sequencer:
//   - default operand / count widths (DATA_W, COUNT_W)
//   - 3-bit FSM state encoding (IDLE, CLEAR, WAIT, PULSE, FINISH)
// No ports (package).
// -----------------------------------------------------------------------------
package accum_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] PULSE  = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

endpackage

// File: rtl/accum_sequencer_op_counter.sv
// -----------------------------------------------------------------------------
// op_counter
// Down-counter holding the number of operands still to be accumulated.
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   synchronous active-low reset (clears the count)
//   load       in   load load_value (has priority over dec)
//   load_value in   COUNT_W value to load
//   dec        in   decrement by one (saturates at zero)
//   is_one     out  count == 1
//   is_zero    out  count == 0
// -----------------------------------------------------------------------------
module op_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               dec,
    output logic               is_one,
    output logic               is_zero
);

    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            // Zero guard is belt-and-braces: the FSM never decrements at zero.
            count_reg <= count_reg - COUNT_W'(1);
        end
    end

    assign is_one  = (count_reg == COUNT_W'(1));
    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
// Feeds a batch of operands to the downstream 8-bit accumulator: one Clear
// pulse per batch, one En pulse per operand (A stable during En), then Done.
// Optional feature macro: ACCUM_SEQ_ABORT_EN (adds the Abort input).
// Ports:
//   Clk       in   system clock, rising edge
//   Reset_n   in   synchronous active-low reset
//   Abort     in   (ACCUM_SEQ_ABORT_EN only) drop the batch from CLEAR/WAIT/PULSE
//   Start     in   begin a batch, sampled in IDLE only
//   Count     in   operands in the batch, latched with Start
//   In_Data   in   operand byte
//   In_Valid  in   In_Data valid
//   In_Ready  out  operand accepted at this edge if In_Valid
//   A         out  registered operand to the accumulator
//   En        out  one-cycle accumulate pulse
//   Clear     out  one-cycle accumulator clear pulse
//   Busy      out  high outside IDLE
//   Done      out  one-cycle batch-complete pulse
// All outputs are registers or decodes of registers; no input-to-output path.
// -----------------------------------------------------------------------------
module accum_sequencer #(
    parameter int DATA_W  = accum_seq_pkg::DATA_W,
    parameter int COUNT_W = accum_seq_pkg::COUNT_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
`ifdef ACCUM_SEQ_ABORT_EN
    input  logic               Abort,
`endif
    input  logic               Start,
    input  logic [COUNT_W-1:0] Count,
    input  logic [DATA_W-1:0]  In_Data,
    input  logic               In_Valid,
    output logic               In_Ready,
    output logic [DATA_W-1:0]  A,
    output logic               En,
    output logic               Clear,
    output logic               Busy,
    output logic               Done
);

    import accum_seq_pkg::*;

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] a_reg;
    logic              abort_hit;
    logic              cnt_is_one;
    logic              cnt_is_zero;
    logic              clear_state;

`ifdef ACCUM_SEQ_ABORT_EN
    logic abort_clear_reg;

    // Abort only matters while a batch is in flight.
    assign abort_hit = Abort && ((state_reg == CLEAR) ||
                                 (state_reg == WAIT)  ||
                                 (state_reg == PULSE));

    // Re-clears the accumulator in the cycle after an abort so a partial sum
    // never lingers downstream.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            abort_clear_reg <= 1'b0;
        end else begin
            abort_clear_reg <= abort_hit;
        end
    end

    assign Clear = clear_state || abort_clear_reg;
`else
    assign abort_hit = 1'b0;
    assign Clear     = clear_state;
`endif

    op_counter #(
        .COUNT_W (COUNT_W)
    ) u_op_counter (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       ((state_reg == IDLE) && Start),
        .load_value (Count),
        .dec        ((state_reg == PULSE) && !abort_hit),
        .is_one     (cnt_is_one),
        .is_zero    (cnt_is_zero)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = CLEAR;
            CLEAR:   state_next = cnt_is_zero ? FINISH : WAIT;
            WAIT:    if (In_Valid) state_next = PULSE;
            // Deciding on ==1 before the decrement keeps the counter from wrapping.
            PULSE:   state_next = cnt_is_one ? FINISH : WAIT;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    // Operand register: loads only on an accepted transfer, so it holds its
    // value through PULSE, between operands and after Done.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            a_reg <= '0;
        end else if ((state_reg == WAIT) && In_Valid && !abort_hit) begin
            a_reg <= In_Data;
        end
    end

    // Output decode (state only)
    always_comb begin
        In_Ready    = 1'b0;
        En          = 1'b0;
        clear_state = 1'b0;
        Done        = 1'b0;
        Busy        = (state_reg != IDLE);
        case (state_reg)
            CLEAR:   clear_state = 1'b1;
            WAIT:    In_Ready    = 1'b1;
            PULSE:   En          = 1'b1;
            FINISH:  Done        = 1'b1;
            default: ;
        endcase
    end

    assign A = a_reg;

endmodule

// File: tb/tb_accum_sequencer.sv
// -----------------------------------------------------------------------------
// tb_accum_sequencer
// Table-driven bench for accum_sequencer with a small downstream accumulator
// model (Clear zeroes the sum, En adds A). Optional Abort vector is built
// when ACCUM_SEQ_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_accum_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [7:0] Count;
    logic [7:0] In_Data;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] A;
    logic       En;
    logic       Clear;
    logic       Busy;
    logic       Done;
`ifdef ACCUM_SEQ_ABORT_EN
    logic       Abort;
`endif

    always #5 Clk = ~Clk;

    accum_sequencer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
`ifdef ACCUM_SEQ_ABORT_EN
        .Abort    (Abort),
`endif
        .Start    (Start),
        .Count    (Count),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .A        (A),
        .En       (En),
        .Clear    (Clear),
        .Busy     (Busy),
        .Done     (Done)
    );

    // kill_kind: 0 none, 1 reset after kill_at En pulses,
    //            2 abort in the WAIT following kill_at En pulses.
    // exp_cycles counts CLEAR..FINISH inclusive; -1 = not checked.
    typedef struct {
        int          count;
        logic [7:0]  first;
        logic [7:0]  step;
        int          stall;
        int          poke;
        int          kill_kind;
        int          kill_at;
        int          exp_en;
        logic [15:0] exp_sum;
        int          exp_clears;
        int          exp_done;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cycles = 0;
        int          en = 0;
        int          clears = 0;
        int          dones = 0;
        int          sent = 0;
        int          stall_left = 0;
        int          post = 0;
        bit          killed = 0;
        bit          timed_out = 0;
        logic [15:0] sum = '0;
        logic [7:0]  exp_b;

        @(negedge Clk);
        Start    = 1'b1;
        Count    = v.count[7:0];
        In_Valid = 1'b0;
        forever begin
            @(negedge Clk);
            cycles++;
            if (Clear) begin
                clears++;
                sum = '0;
            end
            if (En) begin
                exp_b = v.first + 8'(en) * v.step;
                check($sformatf("v%0d_A_at_En%0d", idx, en), A, exp_b);
                sum = sum + 16'(A);
                en++;
            end
            if (Done) dones++;

            if (killed) begin
                if (post == 0) begin
                    check($sformatf("v%0d_busy_after_kill", idx), Busy, 0);
                    check($sformatf("v%0d_en_ready_after_kill", idx), {En, In_Ready}, 0);
                end
                Reset_n  = 1'b1;
                Start    = 1'b0;
                In_Valid = 1'b0;
`ifdef ACCUM_SEQ_ABORT_EN
                Abort    = 1'b0;
`endif
                post++;
                if (post == 6) break;
                continue;
            end
            if (Done) break;
            if (cycles > 2000) begin
                timed_out = 1;
                break;
            end

            Start = (v.poke != 0) && (cycles == 2 || cycles == 3);
            Count = (v.poke != 0) ? 8'd5 : v.count[7:0];

            if (v.kill_kind == 1 && En && en == v.kill_at) begin
                Reset_n  = 1'b0;
                In_Valid = 1'b0;
                killed   = 1;
                continue;
            end
`ifdef ACCUM_SEQ_ABORT_EN
            if (v.kill_kind == 2 && In_Ready && en == v.kill_at) begin
                Abort    = 1'b1;
                In_Valid = 1'b0;
                killed   = 1;
                continue;
            end
`endif
            // Producer: valid held high, optional stall in WAIT after byte 0.
            In_Data = v.first + 8'(sent) * v.step;
            if (In_Ready && stall_left > 0) begin
                In_Valid = 1'b0;
                stall_left--;
            end else begin
                In_Valid = (sent < v.count);
                if (In_Valid && In_Ready) begin
                    sent++;
                    if (sent == 1) stall_left = v.stall;
                end
            end
        end
        Start    = 1'b0;
        In_Valid = 1'b0;
        Reset_n  = 1'b1;

        if (timed_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d_timeout: no Done within 2000 cycles, expected Done", idx);
        end
        check($sformatf("v%0d_en_count", idx), en, v.exp_en);
        check($sformatf("v%0d_sum", idx), sum, v.exp_sum);
        check($sformatf("v%0d_clear_count", idx), clears, v.exp_clears);
        check($sformatf("v%0d_done_count", idx), dones, v.exp_done);
        if (v.exp_cycles >= 0)
            check($sformatf("v%0d_latency", idx), cycles, v.exp_cycles);
        $display("vec %0d: count=%0d en=%0d sum=0x%04h clears=%0d done=%0d cycles=%0d",
                 idx, v.count, en, sum, clears, dones, cycles);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //              cnt  first  step  stl pk kk ka  en  sum        clr dn cyc
        vecs.push_back('{3,   8'h10, 8'h10, 0, 0, 0, 0, 3,  16'h0060, 1,  1, 8});
        vecs.push_back('{2,   8'h5A, 8'h11, 5, 0, 0, 0, 2,  16'h00C5, 1,  1, 11});
        vecs.push_back('{0,   8'h00, 8'h00, 0, 0, 0, 0, 0,  16'h0000, 1,  1, 2});
        vecs.push_back('{255, 8'hFF, 8'h00, 0, 0, 0, 0, 255,16'hFE01, 1,  1, 512});
        vecs.push_back('{3,   8'h01, 8'h01, 0, 1, 0, 0, 3,  16'h0006, 1,  1, 8});
        vecs.push_back('{4,   8'h01, 8'h01, 0, 0, 1, 2, 2,  16'h0003, 1,  0, -1});
`ifdef ACCUM_SEQ_ABORT_EN
        vecs.push_back('{4,   8'h01, 8'h01, 0, 0, 2, 1, 1,  16'h0000, 2,  0, -1});
`endif
        vecs.push_back('{1,   8'h80, 8'h00, 0, 0, 0, 0, 1,  16'h0080, 1,  1, 4});

        // Reset held with Start asserted: nothing may start.
        Reset_n  = 1'b0;
        Start    = 1'b1;
        Count    = 8'd3;
        In_Data  = 8'h00;
        In_Valid = 1'b0;
`ifdef ACCUM_SEQ_ABORT_EN
        Abort    = 1'b0;
`endif
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            check($sformatf("reset_outputs_c%0d", c),
                  {In_Ready, En, Clear, Busy, Done, A}, 0);
            $display("reset cycle %0d: busy=%0b clear=%0b A=0x%02h", c, Busy, Clear, A);
        end
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_after_reset", {Busy, Clear}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
